// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with word-serial line refill
// from the SPI flash controller. Flash words arrive MSB-first and are stored
// byte-swapped so fetches return little-endian instructions.
module icache_dm #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        fetch_req,
    input  logic [19:0] fetch_addr,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    input  logic        flush,
    output logic        icache_miss,
    output logic [19:0] icache_addr,
    input  logic        SPI_data_ready,
    input  logic [31:0] SPI_data,
    output logic [15:0] miss_count
);

    localparam int unsigned WB = $clog2(WORDS);
    localparam int unsigned IB = $clog2(LINES);
    localparam int unsigned TW = 20 - 2 - WB - IB;

    typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

    state_t          state_q, state_d;
    logic [WB-1:0]   wc_q;
    logic            abort_q;
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]   tag_q  [LINES];
    logic [31:0]     data_q [LINES][WORDS];

    logic [WB-1:0]   f_word;
    logic [IB-1:0]   f_idx;
    logic [TW-1:0]   f_tag;
    logic [IB-1:0]   r_idx;
    logic [TW-1:0]   r_tag;
    logic            hit_c;
    logic            start_c;
    logic            accept_c;
    logic            finish_c;
    logic [31:0]     swapped_c;
    logic            unused_c;

    assign f_word = fetch_addr[2 +: WB];
    assign f_idx  = fetch_addr[2 + WB +: IB];
    assign f_tag  = fetch_addr[19 -: TW];
    // The refill line's index and tag live in the request address register.
    assign r_idx  = icache_addr[2 + WB +: IB];
    assign r_tag  = icache_addr[19 -: TW];
    assign unused_c = ^fetch_addr[1:0];

    assign swapped_c = {SPI_data[7:0], SPI_data[15:8], SPI_data[23:16], SPI_data[31:24]};

    // Combinational hit path: zero-latency fetch return.
    assign hit_c       = fetch_req && (state_q == IDLE) && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign fetch_valid = hit_c;
    assign fetch_data  = data_q[f_idx][f_word];

    // State register.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state and refill control strobes.
    always_comb begin
        state_d  = state_q;
        start_c  = 1'b0;
        accept_c = 1'b0;
        finish_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_req && !hit_c) begin
                    start_c = 1'b1;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (SPI_data_ready) begin
                    accept_c = 1'b1;
                    // A flush ends the refill after the in-flight word; SPI cannot be cut.
                    if ((wc_q == WB'(WORDS - 1)) || abort_q || flush) begin
                        finish_c = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request address, word counter, abort flag, valid bits and refill counter.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            icache_miss <= 1'b0;
            icache_addr <= 20'd0;
            wc_q        <= '0;
            abort_q     <= 1'b0;
            valid_q     <= '0;
            miss_count  <= 16'd0;
        end else begin
            if (start_c) begin
                icache_miss     <= 1'b1;
                icache_addr     <= {f_tag, f_idx, (WB + 2)'(0)};
                wc_q            <= '0;
                abort_q         <= 1'b0;
                valid_q[f_idx]  <= 1'b0;
                miss_count      <= miss_count + 16'd1;
            end
            if (accept_c) begin
                if (finish_c) begin
                    icache_miss <= 1'b0;
                    if (!abort_q && !flush) valid_q[r_idx] <= 1'b1;
                end else begin
                    wc_q        <= wc_q + WB'(1);
                    icache_addr <= icache_addr + 20'd4;
                end
            end
            if (state_q == DONE) abort_q <= 1'b0;
            if (flush) begin
                valid_q <= '0;
                if ((state_q == REFILL) && !finish_c) abort_q <= 1'b1;
            end
        end
    end

    // Line data and tag storage; contents are meaningless until valid is set.
    always_ff @(posedge CLK) begin
        if (accept_c) data_q[r_idx][wc_q] <= swapped_c;
        if (finish_c) tag_q[r_idx] <= r_tag;
    end

endmodule
